// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - dmctrl (funct3) encodings
//   - FSM state enum
//   - byte-lane mask constants and helpers (lane mask, load extension)
package dmem_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW, S_WR, S_RSP} state_e;

  // Captured request attributes (word index kept separately: its width is a parameter)
  typedef struct packed {
    logic        wr;
    logic [2:0]  ctrl;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] ctrl, input logic [1:0] off);
    logic [3:0] m;
    case (ctrl)
      DM_B, DM_BU: m = LANE_B;
      DM_H, DM_HU: m = LANE_H;
      default:     m = LANE_W;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] ctrl, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      DM_B:    r = {{24{b[7]}}, b};
      DM_BU:   r = {24'h0, b};
      DM_H:    r = {{16{h[15]}}, h};
      DM_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory request/response bus.
//   master : core side (drives request, sees ready/response)
//   slave  : responder side
interface dmem_responder_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              dmwr;
  logic [2:0]        dmctrl;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req_valid, dmwr, dmctrl, addr, wdata,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, dmwr, dmctrl, addr, wdata,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, DEPTH x 32, one write enable,
// registered read (o_rdata updates on the edge after i_re). No reset.
//   i_clk   clock
//   i_we    write i_wdata to i_addr
//   i_re    load o_rdata from i_addr
module dmem_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a RISC-V core.
//   Loads          IDLE->RD->RSP
//   Word stores    IDLE->WR->RSP
//   Byte/half st.  IDLE->RD->RMW->RSP (read-modify-write)
//   Errors         IDLE->RSP with err=1
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         dmem_responder_if.slave (request/response handshake)
// Option: DMEM_MISALIGN_TRAP_EN -- misaligned H/HU/W trap with err=1; when
// undefined the offending low address bits are cleared instead.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);
  localparam int WAW = ADDR_W - 2;

  state_e          r_state, w_nxt;
  req_t            r_req;
  logic [WAW-1:0]  r_widx;
  logic            r_live;     // holds req_ready low until the first edge after reset
  logic            w_accept;
  logic            w_legal, w_st_bad, w_err;
  logic [1:0]      w_off;
  logic            w_ram_we, w_ram_re;
  logic [31:0]     w_ram_wdata, w_ram_q;
  logic [3:0]      w_mask;
  logic [3:0][7:0] w_old, w_wsh, w_merged;

  // ---- request decode ----
  always_comb begin
    w_legal  = (bus.dmctrl == DM_B) || (bus.dmctrl == DM_H) || (bus.dmctrl == DM_W) ||
               (bus.dmctrl == DM_BU) || (bus.dmctrl == DM_HU);
    w_st_bad = bus.dmwr && ((bus.dmctrl == DM_BU) || (bus.dmctrl == DM_HU));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err = !w_legal || w_st_bad ||
            (((bus.dmctrl == DM_H) || (bus.dmctrl == DM_HU)) && bus.addr[0]) ||
            ((bus.dmctrl == DM_W) && (bus.addr[1:0] != 2'b00));
    w_off = bus.addr[1:0];
`else
    w_err = !w_legal || w_st_bad;
    if ((bus.dmctrl == DM_H) || (bus.dmctrl == DM_HU)) w_off = {bus.addr[1], 1'b0};
    else if (bus.dmctrl == DM_W)                       w_off = 2'b00;
    else                                               w_off = bus.addr[1:0];
`endif
  end

  assign bus.req_ready = (r_state == S_IDLE) && r_live;
  assign w_accept      = bus.req_valid && bus.req_ready;

  // ---- state and capture registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_req   <= '0;
      r_widx  <= '0;
    end else begin
      r_state <= w_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_req.wr    <= bus.dmwr;
        r_req.ctrl  <= bus.dmctrl;
        r_req.off   <= w_off;
        r_req.wdata <= bus.wdata;
        r_req.err   <= w_err;
        r_widx      <= bus.addr[ADDR_W-1:2];
      end
    end
  end

  // ---- next state / RAM control ----
  always_comb begin
    w_nxt       = r_state;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_wdata = r_req.wdata;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_err)                    w_nxt = S_RSP;
        else if (!bus.dmwr)           w_nxt = S_RD;
        else if (bus.dmctrl == DM_W)  w_nxt = S_WR;
        else                          w_nxt = S_RD;
      end
      S_RD: begin
        w_ram_re = 1'b1;
        w_nxt    = r_req.wr ? S_RMW : S_RSP;
      end
      S_RMW: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = w_merged;
        w_nxt       = S_RSP;
      end
      S_WR: begin
        w_ram_we = 1'b1;
        w_nxt    = S_RSP;
      end
      S_RSP:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // ---- byte-lane merge for sub-word stores ----
  // Store data is replicated across lanes so each lane just picks its own byte.
  always_comb begin
    w_old  = w_ram_q;
    w_mask = lane_mask(r_req.ctrl, r_req.off);
    case (r_req.ctrl)
      DM_B:    w_wsh = {4{r_req.wdata[7:0]}};
      DM_H:    w_wsh = {2{r_req.wdata[15:0]}};
      default: w_wsh = r_req.wdata;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_merged[g] = w_mask[g] ? w_wsh[g] : w_old[g];
  end

  // ---- response ----
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.err       = bus.rsp_valid && r_req.err;
  assign bus.rdata     = (bus.rsp_valid && !r_req.wr && !r_req.err) ?
                         load_ext(r_req.ctrl, r_req.off, w_ram_q) : 32'h0;

  dmem_ram #(.DEPTH(DEPTH_WORDS), .AW(WAW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_widx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );
endmodule
